// File: rtl/rf_wb_queue.sv
// rf_wb_queue -- in-order write-back queue in front of a register-file write port.
//
// Producers post writes through a valid/ready handshake. Accepted writes are
// buffered in a circular FIFO and drained one per cycle into the register-file
// write port unless that port is stalled. A read-address lookup forwards the
// youngest pending data so readers never observe a stale register value.
//
// Parameters:
//   W      word width
//   N      register-file word count (address width AW = $clog2(N))
//   DEPTH  queue entries (power of two, >= 2)
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   i_req_vld/i_req_wa/i_req_wdata    producer write request
//   o_req_rdy                         queue can accept (depends on state only)
//   i_stall                           write port unavailable this cycle
//   o_wen/o_wa/o_wdata                register-file write port
//   i_ra                              forwarding lookup address
//   o_byp_hit/o_byp_data              youngest pending match for i_ra
//   o_cnt                             occupied entries
//
// Build option:
//   RF_WB_QUEUE_COALESCE_EN  when defined, an accepted write whose address
//   matches a valid non-head entry overwrites that entry's data in place
//   instead of allocating a new entry.
module rf_wb_queue #(
   parameter int W     = 32,
   parameter int N     = 32,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(N),
   localparam int AQ   = $clog2(DEPTH),
   localparam int CW   = AQ + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_req_vld,
   input  logic [AW-1:0] i_req_wa,
   input  logic [W-1:0]  i_req_wdata,
   output logic          o_req_rdy,
   input  logic          i_stall,
   output logic          o_wen,
   output logic [AW-1:0] o_wa,
   output logic [W-1:0]  o_wdata,
   input  logic [AW-1:0] i_ra,
   output logic          o_byp_hit,
   output logic [W-1:0]  o_byp_data,
   output logic [CW-1:0] o_cnt
);

   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [DEPTH-1:0] vld_reg;
   logic [AW-1:0]    wa_reg    [DEPTH];
   logic [W-1:0]     wdata_reg [DEPTH];
   logic [AQ-1:0]    head_reg;
   logic [AQ-1:0]    tail_reg;
   logic [CW-1:0]    cnt_reg;

   logic             not_empty;
   logic             push;
   logic             pop;
   logic             alloc;
   logic [DEPTH-1:0] byp_match;

   assign not_empty  = (cnt_reg != '0);
   assign o_req_rdy  = (cnt_reg != FULL_CNT);
   assign o_wen      = not_empty & ~i_stall;
   assign o_wa       = not_empty ? wa_reg[head_reg]    : '0;
   assign o_wdata    = not_empty ? wdata_reg[head_reg] : '0;
   assign o_cnt      = cnt_reg;

   assign push = i_req_vld & o_req_rdy;
   assign pop  = o_wen;

`ifdef RF_WB_QUEUE_COALESCE_EN
   // The head is never a merge target: it may be leaving this very cycle.
   logic [DEPTH-1:0] mrg_match;
   genvar gm;
   generate
      for (gm = 0; gm < DEPTH; gm++) begin : g_mrg
         assign mrg_match[gm] = vld_reg[gm] && (AQ'(gm) != head_reg) &&
                                (wa_reg[gm] == i_req_wa);
      end
   endgenerate
   assign alloc = push & ~(|mrg_match);
`else
   assign alloc = push;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_byp
         assign byp_match[gi] = vld_reg[gi] && (wa_reg[gi] == i_ra);
      end
   endgenerate

   // Walk entries oldest to youngest starting at the head; a later match
   // overrides an earlier one, so the youngest matching entry wins.
   always_comb begin
      o_byp_hit  = 1'b0;
      o_byp_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (byp_match[head_reg + AQ'(k)]) begin
            o_byp_hit  = 1'b1;
            o_byp_data = wdata_reg[head_reg + AQ'(k)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_reg  <= '0;
         head_reg <= '0;
         tail_reg <= '0;
         cnt_reg  <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            wa_reg[k]    <= '0;
            wdata_reg[k] <= '0;
         end
      end else begin
         // Tail can only equal head with a live head entry when full, and a
         // full queue never allocates, so pop and alloc never collide.
         if (pop) begin
            vld_reg[head_reg]   <= 1'b0;
            wa_reg[head_reg]    <= '0;
            wdata_reg[head_reg] <= '0;
            head_reg            <= head_reg + 1'b1;
         end
         if (alloc) begin
            vld_reg[tail_reg]   <= 1'b1;
            wa_reg[tail_reg]    <= i_req_wa;
            wdata_reg[tail_reg] <= i_req_wdata;
            tail_reg            <= tail_reg + 1'b1;
         end
`ifdef RF_WB_QUEUE_COALESCE_EN
         for (int k = 0; k < DEPTH; k++) begin
            if (push && mrg_match[k]) begin
               wdata_reg[k] <= i_req_wdata;
            end
         end
`endif
         case ({alloc, pop})
            2'b10:   cnt_reg <= cnt_reg + 1'b1;
            2'b01:   cnt_reg <= cnt_reg - 1'b1;
            default: cnt_reg <= cnt_reg;
         endcase
      end
   end

endmodule

// File: tb/tb_rf_wb_queue.sv
module tb_rf_wb_queue;

   localparam int W     = 32;
   localparam int N     = 32;
   localparam int DEPTH = 4;
   localparam int AW    = $clog2(N);
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_req_vld;
   logic [AW-1:0] i_req_wa;
   logic [W-1:0]  i_req_wdata;
   logic          o_req_rdy;
   logic          i_stall;
   logic          o_wen;
   logic [AW-1:0] o_wa;
   logic [W-1:0]  o_wdata;
   logic [AW-1:0] i_ra;
   logic          o_byp_hit;
   logic [W-1:0]  o_byp_data;
   logic [CW-1:0] o_cnt;

   rf_wb_queue #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_vld   (i_req_vld),
      .i_req_wa    (i_req_wa),
      .i_req_wdata (i_req_wdata),
      .o_req_rdy   (o_req_rdy),
      .i_stall     (i_stall),
      .o_wen       (o_wen),
      .o_wa        (o_wa),
      .o_wdata     (o_wdata),
      .i_ra        (i_ra),
      .o_byp_hit   (o_byp_hit),
      .o_byp_data  (o_byp_data),
      .o_cnt       (o_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] wa;
      logic [W-1:0]  data;
   } wr_t;

   // Reference model: pending writes in acceptance order, front = oldest.
   wr_t model_q[$];

   int checks = 0;
   int errors = 0;

   // DUT outputs sampled in the most recent cycle (mid-cycle, after inputs settle).
   logic          s_rdy, s_wen, s_hit;
   logic [AW-1:0] s_wa;
   logic [W-1:0]  s_wdata, s_byp;
   logic [CW-1:0] s_cnt;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare every output against the model,
   // then advance the model by the rules of the queue at the clock edge.
   task automatic drive_cycle(input logic r, input logic v, input logic [AW-1:0] wa,
                              input logic [W-1:0] d, input logic s, input logic [AW-1:0] ra);
      logic          e_rdy, e_wen, e_hit, accept, merged;
      logic [AW-1:0] e_wa;
      logic [W-1:0]  e_wdata, e_byp;
      @(negedge clk);
      rst = r; i_req_vld = v; i_req_wa = wa; i_req_wdata = d; i_stall = s; i_ra = ra;
      #1;
      e_rdy   = (model_q.size() < DEPTH);
      e_wen   = (model_q.size() > 0) && !s;
      e_wa    = (model_q.size() > 0) ? model_q[0].wa   : '0;
      e_wdata = (model_q.size() > 0) ? model_q[0].data : '0;
      e_hit   = 1'b0;
      e_byp   = '0;
      for (int i = 0; i < model_q.size(); i++) begin
         if (model_q[i].wa == ra) begin
            e_hit = 1'b1;
            e_byp = model_q[i].data;
         end
      end
      s_rdy = o_req_rdy; s_wen = o_wen; s_wa = o_wa; s_wdata = o_wdata;
      s_hit = o_byp_hit; s_byp = o_byp_data; s_cnt = o_cnt;
      check("rdy",      64'(o_req_rdy),  64'(e_rdy));
      check("wen",      64'(o_wen),      64'(e_wen));
      check("wa",       64'(o_wa),       64'(e_wa));
      check("wdata",    64'(o_wdata),    64'(e_wdata));
      check("byp_hit",  64'(o_byp_hit),  64'(e_hit));
      check("byp_data", 64'(o_byp_data), 64'(e_byp));
      check("cnt",      64'(o_cnt),      64'(model_q.size()));
      @(posedge clk);
      if (r) begin
         model_q.delete();
      end else begin
         accept = v && e_rdy;
         merged = 1'b0;
`ifdef RF_WB_QUEUE_COALESCE_EN
         if (accept) begin
            for (int i = 1; i < model_q.size(); i++) begin
               if (model_q[i].wa == wa) begin
                  model_q[i].data = d;
                  merged = 1'b1;
               end
            end
         end
`endif
         if (e_wen) void'(model_q.pop_front());
         if (accept && !merged) model_q.push_back('{wa: wa, data: d});
      end
   endtask

   task automatic idle(input logic s, input logic [AW-1:0] ra);
      drive_cycle(1'b0, 1'b0, '0, '0, s, ra);
   endtask

   initial begin
      rst = 1'b1; i_req_vld = 1'b0; i_req_wa = '0; i_req_wdata = '0; i_stall = 1'b0; i_ra = '0;
      repeat (2) @(posedge clk);

      // Reset state
      idle(1'b0, 5'd0);
      check("reset_rdy", 64'(s_rdy), 64'd1);
      check("reset_wen", 64'(s_wen), 64'd0);
      check("reset_cnt", 64'(s_cnt), 64'd0);
      check("reset_hit", 64'(s_hit), 64'd0);

      // Basic: one write appears on the port the next cycle
      drive_cycle(1'b0, 1'b1, 5'd3, 32'hA5, 1'b0, 5'd0);
      idle(1'b0, 5'd3);
      check("basic_wen",   64'(s_wen),   64'd1);
      check("basic_wa",    64'(s_wa),    64'd3);
      check("basic_wdata", 64'(s_wdata), 64'hA5);
      check("basic_fwd",   64'(s_byp),   64'hA5);
      idle(1'b0, 5'd0);
      check("basic_cnt", 64'(s_cnt), 64'd0);

      // Fill while stalled, then drain in order
      for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 5'(k), 32'(16 + k), 1'b1, 5'd0);
      idle(1'b1, 5'd0);
      check("fill_rdy", 64'(s_rdy), 64'd0);
      check("fill_cnt", 64'(s_cnt), 64'd4);
      for (int k = 0; k < 4; k++) begin
         idle(1'b0, 5'd0);
         check("drain_wen", 64'(s_wen), 64'd1);
         check("drain_wa",  64'(s_wa),  64'(k));
         if (k == 1) check("drain_rdy", 64'(s_rdy), 64'd1);
      end

      // Forwarding picks the youngest match
      drive_cycle(1'b0, 1'b1, 5'd5, 32'h11, 1'b1, 5'd0);
      drive_cycle(1'b0, 1'b1, 5'd5, 32'h22, 1'b1, 5'd0);
      idle(1'b1, 5'd5);
      check("fwd_hit",  64'(s_hit), 64'd1);
      check("fwd_data", 64'(s_byp), 64'h22);
      idle(1'b1, 5'd6);
      check("fwd_miss_hit",  64'(s_hit), 64'd0);
      check("fwd_miss_data", 64'(s_byp), 64'd0);
      repeat (3) idle(1'b0, 5'd5);

      // Full with simultaneous drain: refused now, accepted a cycle later
      for (int k = 0; k < 4; k++) drive_cycle(1'b0, 1'b1, 5'(8 + k), 32'(32 + k), 1'b1, 5'd0);
      drive_cycle(1'b0, 1'b1, 5'd20, 32'h77, 1'b0, 5'd0);
      check("full_rdy", 64'(s_rdy), 64'd0);
      check("full_wen", 64'(s_wen), 64'd1);
      drive_cycle(1'b0, 1'b1, 5'd20, 32'h77, 1'b1, 5'd20);
      check("full_cnt3", 64'(s_cnt), 64'd3);
      check("full_rdy1", 64'(s_rdy), 64'd1);
      idle(1'b1, 5'd20);
      check("full_cnt4", 64'(s_cnt), 64'd4);
      check("full_fwd",  64'(s_byp), 64'h77);
      repeat (5) idle(1'b0, 5'd0);

      // Reset mid-operation discards pending writes
      for (int k = 0; k < 3; k++) drive_cycle(1'b0, 1'b1, 5'(12 + k), 32'(48 + k), 1'b1, 5'd0);
      drive_cycle(1'b1, 1'b1, 5'd15, 32'h99, 1'b0, 5'd12);
      idle(1'b0, 5'd12);
      check("rst_wen", 64'(s_wen), 64'd0);
      check("rst_cnt", 64'(s_cnt), 64'd0);
      check("rst_hit", 64'(s_hit), 64'd0);
      repeat (3) idle(1'b0, 5'd0);

`ifdef RF_WB_QUEUE_COALESCE_EN
      drive_cycle(1'b0, 1'b1, 5'd2, 32'h1, 1'b1, 5'd0);
      drive_cycle(1'b0, 1'b1, 5'd7, 32'h2, 1'b1, 5'd0);
      drive_cycle(1'b0, 1'b1, 5'd7, 32'h3, 1'b1, 5'd0);
      idle(1'b1, 5'd7);
      check("coal_cnt", 64'(s_cnt), 64'd2);
      idle(1'b0, 5'd0);
      check("coal_wa0",   64'(s_wa),    64'd2);
      check("coal_data0", 64'(s_wdata), 64'h1);
      idle(1'b0, 5'd0);
      check("coal_wa1",   64'(s_wa),    64'd7);
      check("coal_data1", 64'(s_wdata), 64'h3);
      idle(1'b0, 5'd0);
`endif

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         drive_cycle(($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 1) == 1),
                     5'($urandom_range(0, 7)),
                     $urandom(),
                     ($urandom_range(0, 9) < 3),
                     5'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Write-back queue that sits in front of a register-file write port and acts as that port's initiator. Producers post writes through a valid/ready handshake. The queue buffers them in order and drains one per cycle into the register file's write port, unless the port is stalled. It also forwards the youngest pending data for a read address, so readers never see a stale word while a write is still queued.

## Interface
Parameters:
- W, 32, word width (bits)
- N, 32, register-file word count; address width AW = $clog2(N)
- DEPTH, 4, queue entries (power of two, >= 2)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- i_req_vld  in  1  producer write request valid
- i_req_wa  in  AW  producer write address
- i_req_wdata  in  W  producer write data
- o_req_rdy  out  1  queue can accept a request
- i_stall  in  1  register-file write port unavailable this cycle
- o_wen  out  1  register-file write enable
- o_wa  out  AW  register-file write address
- o_wdata  out  W  register-file write data
- i_ra  in  AW  forwarding lookup address
- o_byp_hit  out  1  a pending entry matches i_ra
- o_byp_data  out  W  data of the youngest matching pending entry
- o_cnt  out  $clog2(DEPTH)+1  number of occupied entries

## Operation
- **Storage:** circular FIFO of DEPTH entries, each holding {vld, wa, wdata}. Head and tail pointers are AW_Q = $clog2(DEPTH) bits and wrap modulo DEPTH. o_cnt is a separate counter.
- **Enqueue:** occurs when i_req_vld & o_req_rdy. The request is written at the tail and the tail advances.
  - o_req_rdy = (o_cnt != DEPTH).
  - o_req_rdy is registered-state only and has no combinational dependency on i_stall or i_req_*.
- **Drain:** o_wen = (o_cnt != 0) & ~i_stall.
  - When o_cnt != 0, o_wa and o_wdata present the head entry; otherwise both are 0.
  - When o_wen = 1, the head entry is cleared and the head pointer advances at the clock edge.
- **Simultaneous enqueue and drain:** o_cnt is unchanged. This is legal when full: the drain frees the head entry while rdy was already 0, so no enqueue happens, and rdy rises the next cycle.
- **Forwarding:** o_byp_hit = OR over valid entries with wa == i_ra.
  - o_byp_data comes from the youngest such entry (closest to the tail), found by age-ordered priority from tail-1 backwards.
  - The head entry participates even in the cycle it drains, because the register-file write lands only at the edge.
  - A request being enqueued in the same cycle is not visible to forwarding.
  - When o_byp_hit = 0, o_byp_data = 0.
- **Ordering:** writes reach the register file in acceptance order. Never reorder.
- **Reset:** all entries are invalidated, pointers and o_cnt go to 0.
  - Reset wins over a concurrent enqueue or drain.
  - Pending writes are discarded, not drained.

## Timing
- **Reset values:** o_req_rdy=1, o_wen=0, o_wa=0, o_wdata=0, o_byp_hit=0, o_byp_data=0, o_cnt=0.
- **Latency:** a request accepted at edge t appears on o_wen/o_wa/o_wdata in cycle t+1 at the earliest, when the queue was empty and i_stall=0.
- **Forwarding timing:** forwarding for an accepted request is valid from cycle t+1 until the cycle its drain fires, inclusive.
- **Stall:** i_stall holds the head. Entries and o_wa/o_wdata stay stable across stall cycles.
- **Combinational paths:**
  - i_stall to o_wen.
  - i_ra to o_byp_hit and o_byp_data.
  - There is no path from i_req_* to any output.

## Configuration
- Macro: RF_WB_QUEUE_COALESCE_EN.
- **Defined:** an accepted request whose wa matches a valid non-head entry overwrites that entry's wdata in place.
  - The tail and o_cnt do not change.
  - Because merges always target a non-head entry, at most one non-head entry exists per address.
  - The head is excluded because it may be draining this cycle.
  - o_req_rdy is unchanged (= !full), so a merge is still refused when full.
- **Undefined:** every accepted request allocates a new entry. There is no comparator on the enqueue path.

## Test plan
- **Basic:** reset, then enqueue {wa=3, wdata=0xA5} at cycle 1.
  - Required: o_wen=1, o_wa=3, o_wdata=0xA5 in cycle 2, then o_cnt=0.
- **Fill and stall:** hold i_stall=1 and enqueue 4 writes (wa=0..3).
  - Required: o_req_rdy=0 and o_cnt=4.
  - Then release the stall. Required: four consecutive o_wen pulses with wa 0,1,2,3 in order, and o_req_rdy=1 the cycle after the first drain.
- **Forwarding:** with i_stall=1, enqueue wa=5/0x11 then wa=5/0x22, and drive i_ra=5.
  - Required: o_byp_hit=1, o_byp_data=0x22.
  - Required with i_ra=6: o_byp_hit=0, o_byp_data=0.
- **Full with simultaneous drain:** at DEPTH with i_stall=0 and i_req_vld=1.
  - Required: no accept that cycle, o_cnt=3 next cycle, and the accept lands the following cycle.
- **Reset mid-operation:** assert rst with 3 pending entries.
  - Required: o_wen=0 and o_cnt=0 next cycle, and none of the discarded writes ever appear.
- **Coalescing (RF_WB_QUEUE_COALESCE_EN):** stalled, enqueue wa=2/0x1, wa=7/0x2, wa=7/0x3.
  - Required: o_cnt=2, and draining produces wa=2/0x1 then wa=7/0x3.
